// File: rtl/cmp_sched.sv
// cmp_sched: round-robin scheduler sharing one pipelined comparator among N requesters
module cmp_sched #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N*3-1:0] req_op,
  output logic [N-1:0]   rsp_valid,
  output logic [N-1:0]   rsp_z,
  output logic [W-1:0]   cmp_a,
  output logic [W-1:0]   cmp_b,
  output logic [2:0]     cmp_op,
  output logic           cmp_issue,
  input  logic           cmp_z
);
  localparam int PW = $clog2(N);
  logic [PW-1:0]          ptr_q, ptr_d, gnt;
  logic [N-1:0]           busy_q, busy_d, elig, rsp_hit, rsp_valid_q, rsp_z_q;
  logic                   hs, issue_q;
  logic [LAT:0]           tv_q;
  logic [LAT:0][PW-1:0]   tid_q;
  logic [W-1:0]           a_q, b_q;
  logic [2:0]             op_q;
  // Round-robin grant: the first eligible requester at or after the pointer wins
  always_comb begin
    elig = req_valid & ~busy_q;
    gnt = '0;
    for (int o = N - 1; o >= 0; o--)
      if (elig[(int'(ptr_q) + o) % N]) gnt = PW'((int'(ptr_q) + o) % N);
    hs = |elig;
    req_ready = hs ? N'(1) << gnt : '0;
    rsp_hit = tv_q[LAT] ? N'(1) << tid_q[LAT] : '0;
    busy_d = (busy_q & ~rsp_hit) | req_ready;
    ptr_d = hs ? PW'((int'(gnt) + 1) % N) : ptr_q;
  end
  // Issue registers, tag pipeline aligned with cmp_z, and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      busy_q <= '0;
      tv_q <= '0;
      tid_q <= '0;
      issue_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      rsp_valid_q <= '0;
      rsp_z_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      busy_q <= busy_d;
      tv_q <= {tv_q[LAT-1:0], hs};
      tid_q <= {tid_q[LAT-1:0], gnt};
      issue_q <= hs;
      if (hs) begin
        a_q <= req_a[int'(gnt)*W +: W];
        b_q <= req_b[int'(gnt)*W +: W];
        op_q <= req_op[int'(gnt)*3 +: 3];
      end
      rsp_valid_q <= rsp_hit;
      rsp_z_q <= cmp_z ? rsp_hit : '0;
    end
  end
  assign cmp_a = a_q;
  assign cmp_b = b_q;
  assign cmp_op = op_q;
  assign cmp_issue = issue_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_z = rsp_z_q;
endmodule

// File: doc/cmp_sched.md
Name: cmp_sched

Overview:
- Round-robin scheduler that shares one pipelined comparator unit (eq/ne/lt/le family, W-bit operands, LAT registered stages) between N requesters.
- Accepts requests through valid/ready handshakes and drives the shared comparator's operand and opcode inputs.
- Tracks in-flight tags and returns each 1-bit result to the requester that issued it.
- Sits between the arithmetic/control clients and the single comparator instance, so the design needs one comparator rather than N.

Parameters:
- N, 4, number of requesters (2..8)
- W, 32, operand width in bits
- LAT, 1, register stages in the shared comparator from its input to cmp_z (1..4)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N  per-requester request valid
- req_ready  output  N  per-requester accept; at most one bit high per cycle
- req_a  input  N*W  operand A; requester i in bits [i*W +: W]
- req_b  input  N*W  operand B; same packing as req_a
- req_op  input  N*3  opcode; requester i in bits [i*3 +: 3]; passed through unmodified
- rsp_valid  output  N  one-cycle result strobe per requester
- rsp_z  output  N  result bit per requester; meaningful only while the matching rsp_valid is high
- cmp_a  output  W  shared comparator operand A
- cmp_b  output  W  shared comparator operand B
- cmp_op  output  3  shared comparator opcode
- cmp_issue  output  1  high for one cycle when cmp_a/cmp_b/cmp_op carry a new operation
- cmp_z  input  1  shared comparator result, valid LAT cycles after the cycle in which it was issued

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values:
  - req_ready, rsp_valid, rsp_z, cmp_issue: 0.
  - cmp_a, cmp_b, cmp_op: 0.
  - Round-robin pointer: 0, so requester 0 has highest priority.
  - busy[N]: 0.
  - Tag pipeline valid bits: 0.
- Per-requester state: IDLE -> BUSY on handshake; BUSY -> IDLE on the edge that raises its rsp_valid. Each requester has at most one operation outstanding.
- Eligibility: requester i is eligible when req_valid[i]=1 and busy[i]=0.
- Grant:
  - Combinational, round-robin over eligible requesters, starting the search at the pointer.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid.
- Handshake: req_valid[i] & req_ready[i] at a rising edge T0.
  - At T0: cmp_a/cmp_b/cmp_op load requester i's fields; cmp_issue=1 for the cycle after T0.
  - At T0: the tag pipeline entry loads {valid=1, id=i}; busy[i] is set; pointer becomes (i+1) mod N.
- No handshake: cmp_issue=0; cmp_a/cmp_b/cmp_op hold their previous values; pointer is unchanged.
- Tag pipeline: LAT+1 entries deep, advanced every cycle, aligned so the head tag matches the cycle in which cmp_z for that operation is valid.
- Response:
  - When the head tag is valid with id j, rsp_z[j] captures cmp_z and rsp_valid[j]=1 for exactly one cycle.
  - Total latency: rsp_valid asserts LAT+1 cycles after handshake edge T0 (LAT=1 gives the cycle after edge T0+2).
  - rsp_valid bits and rsp_z bits of non-responding requesters are 0.
- Throughput: one issue per cycle across different requesters. A single requester can re-issue in its rsp_valid cycle, so handshake cadence per requester is LAT+2 cycles.
- Simultaneous events:
  - A requester's response and a new grant to that same requester never coincide, because busy is cleared on the rsp edge.
  - A response to j and a grant to k≠j in the same cycle are both serviced.
- req_valid dropped before handshake: legal; no operation is issued and the grant moves on.
- Reset mid-operation: all in-flight tags are discarded; no rsp_valid follows reset even if cmp_z toggles; busy is cleared.
- Opcode values: none are interpreted; reserved opcodes pass through to cmp_op unchanged.

Test Plan:
- Reset then idle, all req_valid=0 -> req_ready=0, cmp_issue=0, rsp_valid=0 for 20 cycles.
- Single request, LAT=1, req0 a=5 b=7 op=1 (ne), behavioural comparator model -> cmp_a=5, cmp_b=7, cmp_op=1, cmp_issue=1 the cycle after the handshake; rsp_valid[0]=1 with rsp_z[0]=1 exactly 2 cycles after the handshake; no other rsp_valid.
- All 4 requesters valid continuously, each with a=b=i, op=0 -> grants go 0,1,2,3,0,... with one issue per cycle; each rsp_z=1; every requester re-accepted at LAT+2 cadence with no starvation.
- Requests from 1 and 3 held while the pointer=2 -> grant 3 then 1; responses return in issue order with the correct ids.
- Reset asserted one cycle after a handshake -> no rsp_valid follows; after release, req_ready re-grants requester 0 first.
- LAT=3 build, back-to-back issues from 0 and 1 -> rsp_valid[0] and rsp_valid[1] arrive 4 cycles after their respective handshakes, in consecutive cycles.
